// File: rtl/fetch_ctrl_if.sv
// Pipeline front-end control bundle between the pipeline datapath (master)
// and the fetch/hazard controller (slave).
interface fetch_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic              start;
   logic [5:0]        id_opcode;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_uses_rt;
   logic [5:0]        ex_opcode;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_valid;
   logic              ex_redirect;

   logic              run;
   logic              stall;
   logic              bubble_ex;
   logic              flush_ifid;
   logic              halted;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output start, id_opcode, id_rs, id_rt, id_uses_rt,
             ex_opcode, ex_rd, ex_valid, ex_redirect,
      input  run, stall, bubble_ex, flush_ifid, halted, stall_cnt, flush_cnt
   );

   modport slave (
      input  start, id_opcode, id_rs, id_rt, id_uses_rt,
             ex_opcode, ex_rd, ex_valid, ex_redirect,
      output run, stall, bubble_ex, flush_ifid, halted, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Front-end sequencer: load-use stall, redirect flush, start/halt/drain FSM
// and saturating stall/flush performance counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | after reset; fetch held, waiting for start
// S_RUN    | fetching; hazard detection and redirect flushes active
// S_DRAIN  | halt decoded; letting older instructions retire, fetch held
// S_HALTED | pipeline empty; counters held, start resumes RUN
module fetch_ctrl #(
   parameter int          REG_AW    = 5,
   parameter logic [5:0]  LOAD_OP   = 6'b100011,
   parameter logic [5:0]  HALT_OP   = 6'b010001,
   parameter int          DRAIN_CYC = 3,
   parameter int          CNT_W     = 16
) (
   input logic         clk,
   input logic         rst,
   fetch_ctrl_if.slave bus
);
   localparam int DW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;

   state_t            state_q, state_d;
   logic [DW-1:0]     drain_q, drain_d;
   logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

   logic [REG_AW-1:0] ex_rd, id_rs, id_rt;
   logic              load_use;
   logic              halt_dec;
   logic              run, stall, bubble_ex, flush_ifid, halted;

   assign ex_rd = bus.ex_rd;
   assign id_rs = bus.id_rs;
   assign id_rt = bus.id_rt;

   // Register 0 is hardwired, so a load targeting it never creates a hazard.
   assign load_use = bus.ex_valid && (bus.ex_opcode == LOAD_OP) && (ex_rd != '0) &&
                     ((ex_rd == id_rs) || (bus.id_uses_rt && (ex_rd == id_rt)));
   assign halt_dec = (bus.id_opcode == HALT_OP);

   // State and drain-timer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   // Next state and pipeline control outputs.
   always_comb begin
      state_d    = state_q;
      drain_d    = drain_q;
      run        = 1'b0;
      stall      = 1'b0;
      bubble_ex  = 1'b0;
      flush_ifid = 1'b0;
      halted     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            stall = 1'b1;
            if (bus.start) state_d = S_RUN;
         end
         S_RUN: begin
            run = 1'b1;
            if (bus.ex_redirect) begin
               // Younger instructions, including any halt in ID, are wrong-path.
               flush_ifid = 1'b1;
               bubble_ex  = 1'b1;
            end else if (load_use) begin
               // Halt waits behind the stall and is re-evaluated next cycle.
               stall     = 1'b1;
               bubble_ex = 1'b1;
            end else if (halt_dec) begin
               state_d = S_DRAIN;
               drain_d = DW'(DRAIN_CYC);
            end
         end
         S_DRAIN: begin
            stall      = 1'b1;
            flush_ifid = (drain_q == DW'(DRAIN_CYC));
            if (drain_q <= DW'(1)) state_d = S_HALTED;
            else                   drain_d = drain_q - DW'(1);
         end
         S_HALTED: begin
            stall  = 1'b1;
            halted = 1'b1;
            if (bus.start) state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Saturating performance counters, only counting RUN-state events.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (state_q == S_RUN && stall && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (state_q == S_RUN && bus.ex_redirect && flush_cnt_q != '1)
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign bus.run        = run;
   assign bus.stall      = stall;
   assign bus.bubble_ex  = bubble_ex;
   assign bus.flush_ifid = flush_ifid;
   assign bus.halted     = halted;
   assign bus.stall_cnt  = stall_cnt_q;
   assign bus.flush_cnt  = flush_cnt_q;
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the 5-stage pipeline front end.
- Detects load-use hazards and produces the IF/ID stall (the fetch stage's `hazard` input).
- Issues IF/ID and ID/EX flushes on EX-resolved redirects.
- Runs a start/halt/drain state machine, with saturating performance counters for stalls and flushes.

Parameters:
- REG_AW, 5, register index width.
- LOAD_OP, 6'b100011, opcode of the load instruction.
- HALT_OP, 6'b010001, opcode of the halt instruction.
- DRAIN_CYC, 3, cycles after halt decode before the pipeline is considered empty.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins execution from IDLE or HALTED.
- id_opcode  in  6  opcode of the instruction in ID.
- id_rs  in  REG_AW  source register 1 of the ID instruction.
- id_rt  in  REG_AW  source register 2 of the ID instruction.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_opcode  in  6  opcode of the instruction in EX.
- ex_rd  in  REG_AW  destination register of the EX instruction.
- ex_valid  in  1  EX holds a real (non-bubble) instruction.
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle.
- run  out  1  fetch enabled; high only in RUN.
- stall  out  1  hold PC and IF/ID (drives fetch `hazard`).
- bubble_ex  out  1  insert NOP into ID/EX.
- flush_ifid  out  1  clear IF/ID.
- halted  out  1  high in HALTED.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of redirect events.

Behaviour:
- States: IDLE, RUN, DRAIN, HALTED.
  - Reset state IDLE.
  - All counters 0.
  - All outputs 0, except that `stall` is 1 in IDLE.
- IDLE:
  - run=0, stall=1.
  - start -> RUN next cycle.
- RUN:
  - run=1.
  - load_use = ex_valid & ex_opcode==LOAD_OP & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
  - Redirect:
    - ex_redirect -> flush_ifid=1 and bubble_ex=1 in the same cycle (combinational), stall=0.
    - Redirect has priority over load_use; the stalled instruction is on the wrong path.
  - Else load_use -> stall=1 and bubble_ex=1 for exactly that cycle. The next cycle re-evaluates; a 1-cycle load-use gap clears the condition because the load has moved to MEM.
  - Halt decode: id_opcode==HALT_OP with no ex_redirect -> next state DRAIN, drain counter loaded with DRAIN_CYC.
  - Halt decode is ignored when ex_redirect is high in the same cycle (halt is on the wrong path).
  - Halt with load_use in the same cycle: stall wins and the halt is re-evaluated the next cycle.
- DRAIN:
  - run=0, stall=1.
  - flush_ifid=1 only in the first DRAIN cycle, so nothing younger than the halt proceeds.
  - bubble_ex=0.
  - Counter decrements each cycle; at 1 -> HALTED.
  - ex_redirect and load_use are ignored.
  - start is ignored.
- HALTED:
  - halted=1, stall=1, run=0.
  - start -> RUN.
  - Counters are held, not cleared.
- Counters:
  - stall_cnt increments on every RUN cycle with stall=1.
  - flush_cnt increments on every RUN cycle with ex_redirect=1.
  - Both saturate at all-ones.
  - Cleared only by rst.
- Reset mid-operation: rst in any state -> IDLE, counters 0 on the following edge. rst overrides a simultaneous start.
- Register 0 is never a hazard source.

Test Plan:
- rst 2 cycles, then idle -> stall=1, run=0, halted=0, counters 0. Pulse start -> run=1 on the next cycle.
- RUN; ex_opcode=LOAD_OP, ex_rd=5, ex_valid=1, id_rs=5 -> stall=1 and bubble_ex=1 for 1 cycle, stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- RUN; load_use and ex_redirect both high -> flush_ifid=1, bubble_ex=1, stall=0, flush_cnt increments, stall_cnt unchanged.
- RUN; id_opcode=HALT_OP -> DRAIN: flush_ifid=1 for 1 cycle, stall=1 for 3 cycles, then halted=1. Pulse start -> RUN with counters retained.
- HALT_OP decoded in the same cycle as ex_redirect -> remains in RUN, halted stays 0.
- Force stall_cnt to 16'hFFFF via 65535 load-use stalls, then one more -> stays 16'hFFFF. Assert rst in DRAIN -> IDLE, counters 0.
